// File: rtl/quad_decoder.sv
// Quadrature (A/B) encoder decoder.
// Each encoder line passes through a synchroniser and then a run-length filter.
// The filtered Gray-code state is decoded into a one-cycle step pulse, a
// direction flag and a wrap-around position count. An illegal two-bit jump
// sets a sticky error flag.
//
// Output timing: step is high for exactly one clock on each valid transition.
// dir and pos update on that same edge. There is no back-pressure, so a
// consumer must sample step on every clock.
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] pos,
  output logic             err
);

  // The counter only has to reach FILT_LEN-1. It wraps back to 0 when the
  // filtered line accepts the new value.
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
  logic [1:0]             sync_s;   // {sb, sa}
  logic [1:0]             filt_q;   // {fb, fa}
  logic [1:0]             filt_d;
  logic [CW-1:0]          cnt_q [2];
  logic [CW-1:0]          cnt_d [2];
  logic [1:0]             prv_q;

  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             err_q, err_d;
  logic             is_up, is_dn, is_bad;

  // Shift the asynchronous lines through the synchroniser chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], a_in};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], b_in};
    end
  end

  assign sync_s = {sync_b_q[SYNC_STAGES-1], sync_a_q[SYNC_STAGES-1]};

  // A filtered line changes only after FILT_LEN consecutive mismatching samples.
  always_comb begin
    filt_d = filt_q;
    for (int ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = '0;
      if (sync_s[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          filt_d[ch] = sync_s[ch];
          cnt_d[ch]  = '0;
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // Register the filter state. Reset discards any partial mismatch run.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // Classify prv -> cur. The up sequence is 00->01->11->10->00.
  always_comb begin
    is_up  = ((prv_q == 2'b00) && (filt_q == 2'b01)) ||
             ((prv_q == 2'b01) && (filt_q == 2'b11)) ||
             ((prv_q == 2'b11) && (filt_q == 2'b10)) ||
             ((prv_q == 2'b10) && (filt_q == 2'b00));
    is_dn  = ((prv_q == 2'b01) && (filt_q == 2'b00)) ||
             ((prv_q == 2'b11) && (filt_q == 2'b01)) ||
             ((prv_q == 2'b10) && (filt_q == 2'b11)) ||
             ((prv_q == 2'b00) && (filt_q == 2'b10));
    is_bad = ((prv_q ^ filt_q) == 2'b11);

    step_d = is_up | is_dn;
    dir_d  = dir_q;
    if (is_up)      dir_d = 1'b1;
    else if (is_dn) dir_d = 1'b0;

    // clr takes priority over a step in the same cycle.
    pos_d = pos_q;
    if (clr)        pos_d = '0;
    else if (is_up) pos_d = pos_q + WIDTH'(1);
    else if (is_dn) pos_d = pos_q - WIDTH'(1);

    // A fresh illegal jump beats err_clr in the same cycle.
    err_d = err_q;
    if (is_bad)       err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // Register the decoder state. prv always follows cur, so an illegal jump
  // resynchronises the decoder on the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prv_q  <= 2'b00;
      step_q <= 1'b0;
      dir_q  <= 1'b1;
      pos_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      prv_q  <= filt_q;
      step_q <= step_d;
      dir_q  <= dir_d;
      pos_q  <= pos_d;
      err_q  <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign pos  = pos_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with default parameters.
// Inputs change on falling edges and outputs are sampled on falling edges.
// If an input changes at falling edge N0, the step is visible at falling edge N6.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       clr = 1'b0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       dir;
  logic [3:0] pos;
  logic       err;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_pos = 4'd0;

  quad_decoder #(.WIDTH(4), .SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr     (clr),
    .err_clr (err_clr),
    .step    (step),
    .dir     (dir),
    .pos     (pos),
    .err     (err)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_ab(input logic b, input logic a);
    @(negedge clk);
    b_in = b;
    a_in = a;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_pos = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", step); end
    tests++; if (dir !== 1'b1) begin fails++; $display("FAIL reset_dir: got %b want 1", dir); end
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL reset_pos: got %0d want 0", pos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_up();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      set_ab(seq[i][1], seq[i][0]);
      exp_pos = exp_pos + 4'd1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        tests++;
        if (step !== (k == 6)) begin
          fails++; $display("FAIL up_step i=%0d k=%0d: got %b want %b", i, k, step, (k == 6));
        end
        if (k == 6) begin
          tests++; if (dir !== 1'b1) begin fails++; $display("FAIL up_dir i=%0d: got %b want 1", i, dir); end
          tests++; if (pos !== exp_pos) begin fails++; $display("FAIL up_pos i=%0d: got %0d want %0d", i, pos, exp_pos); end
        end
      end
    end
    tests++; if (pos !== 4'd4) begin fails++; $display("FAIL up_final_pos: got %0d want 4", pos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL up_err: got %b want 0", err); end
  endtask

  task automatic test_down();
    logic [1:0] seq [4];
    logic [3:0] want [4];
    seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
    want = '{4'd15, 4'd14, 4'd13, 4'd12};
    pulse_clr();
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL down_clr_pos: got %0d want 0", pos); end
    for (int i = 0; i < 4; i++) begin
      set_ab(seq[i][1], seq[i][0]);
      repeat (6) @(negedge clk);
      tests++; if (step !== 1'b1) begin fails++; $display("FAIL down_step i=%0d: got %b want 1", i, step); end
      tests++; if (dir !== 1'b0) begin fails++; $display("FAIL down_dir i=%0d: got %b want 0", i, dir); end
      tests++; if (pos !== want[i]) begin fails++; $display("FAIL down_pos i=%0d: got %0d want %0d", i, pos, want[i]); end
      repeat (4) @(negedge clk);
    end
    exp_pos = 4'd12;
  endtask

  task automatic test_up_wrap();
    logic [1:0] seq [4];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    pulse_clr();
    for (int i = 0; i < 16; i++) begin
      set_ab(seq[i % 4][1], seq[i % 4][0]);
      exp_pos = exp_pos + 4'd1;
      repeat (6) @(negedge clk);
      tests++; if (step !== 1'b1) begin fails++; $display("FAIL wrap_step i=%0d: got %b want 1", i, step); end
      tests++; if (pos !== exp_pos) begin fails++; $display("FAIL wrap_pos i=%0d: got %0d want %0d", i, pos, exp_pos); end
      repeat (4) @(negedge clk);
    end
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL wrap_final_pos: got %0d want 0", pos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wrap_err: got %b want 0", err); end
  endtask

  task automatic test_glitch();
    // Two-cycle pulse on A: it must never reach the filtered line.
    set_ab(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL glitch_step k=%0d: got %b want 0", k, step); end
    end
    tests++; if (pos !== exp_pos) begin fails++; $display("FAIL glitch_pos: got %0d want %0d", pos, exp_pos); end
    // A held level passes the filter and gives an up step.
    set_ab(1'b0, 1'b1);
    exp_pos = exp_pos + 4'd1;
    repeat (6) @(negedge clk);
    tests++; if (step !== 1'b1) begin fails++; $display("FAIL hold_step: got %b want 1", step); end
    tests++; if (dir !== 1'b1) begin fails++; $display("FAIL hold_dir: got %b want 1", dir); end
    tests++; if (pos !== exp_pos) begin fails++; $display("FAIL hold_pos: got %0d want %0d", pos, exp_pos); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    // Back to 00 (down step), then jump straight to 11.
    set_ab(1'b0, 1'b0);
    exp_pos = exp_pos - 4'd1;
    settle();
    set_ab(1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL illegal_step k=%0d: got %b want 0", k, step); end
    end
    tests++; if (pos !== exp_pos) begin fails++; $display("FAIL illegal_pos: got %0d want %0d", pos, exp_pos); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b want 1", err); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clr: got %b want 0", err); end
    // 11 -> 01 is a down step, then 01 -> 10 lands together with err_clr.
    set_ab(1'b0, 1'b1);
    exp_pos = exp_pos - 4'd1;
    settle();
    tests++; if (pos !== exp_pos) begin fails++; $display("FAIL resync_pos: got %0d want %0d", pos, exp_pos); end
    set_ab(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL pre_illegal_err: got %b want 0", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_clr_vs_illegal: got %b want 1", err); end
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL illegal2_step: got %b want 0", step); end
    settle();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clr2: got %b want 0", err); end
  endtask

  task automatic test_clr_priority();
    logic [1:0] seq [7];
    seq = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    pulse_clr();
    for (int i = 0; i < 7; i++) begin
      set_ab(seq[i][1], seq[i][0]);
      settle();
    end
    tests++; if (pos !== 4'd7) begin fails++; $display("FAIL pre_clr_pos: got %0d want 7", pos); end
    set_ab(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL clr_prio_pos: got %0d want 0", pos); end
    tests++; if (step !== 1'b1) begin fails++; $display("FAIL clr_prio_step: got %b want 1", step); end
    tests++; if (dir !== 1'b1) begin fails++; $display("FAIL clr_prio_dir: got %b want 1", dir); end
    settle();
    exp_pos = 4'd0;
  endtask

  task automatic test_rst_priority();
    // From 10: up to 00 and 01, illegal to 10, then down to 11.
    set_ab(1'b0, 1'b0); settle();
    set_ab(1'b0, 1'b1); settle();
    set_ab(1'b1, 1'b0); settle();
    set_ab(1'b1, 1'b1); settle();
    tests++; if (pos !== 4'd1) begin fails++; $display("FAIL pre_rst_pos: got %0d want 1", pos); end
    tests++; if (dir !== 1'b0) begin fails++; $display("FAIL pre_rst_dir: got %b want 0", dir); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL pre_rst_err: got %b want 1", err); end
    // Down step 11 -> 01 in flight, with rst and clr on its update edge.
    set_ab(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    tests++; if (pos !== 4'd0) begin fails++; $display("FAIL rst_prio_pos: got %0d want 0", pos); end
    tests++; if (dir !== 1'b1) begin fails++; $display("FAIL rst_prio_dir: got %b want 1", dir); end
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL rst_prio_step: got %b want 0", step); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_prio_err: got %b want 0", err); end
    rst = 1'b0;
    clr = 1'b0;
    // Lines still at 01, so filters rise from 00 -> one up step after reset.
    settle();
    tests++; if (pos !== 4'd1) begin fails++; $display("FAIL post_rst_pos: got %0d want 1", pos); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL post_rst_err: got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_up_wrap();
    test_glitch();
    test_illegal();
    test_clr_priority();
    test_rst_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
